led_frame_arbiter: RTL and testbench

//   Shares the 8x4 LED matrix between NREQ requesters.
//   - Round-robin grants exclusive write access to a back frame buffer.
//   - Copies the back buffer to the front buffer only on a scan frame boundary, so the display never tears.
//   - Front buffer drives leds1..leds4 of the LED scan module.

---
 rtl/led_frame_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_led_frame_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_arbiter.sv
// Round-robin owner of an 8x4 LED back buffer; the finished frame is copied to
// the displayed front buffer only on a scanner frame boundary so it never tears.
module led_frame_arbiter #(
    parameter int         NREQ    = 2,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] RST_PAT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    input  logic [NREQ-1:0]   wr_en,
    input  logic [2*NREQ-1:0] wr_col,
    input  logic [8*NREQ-1:0] wr_data,
    input  logic [NREQ-1:0]   commit,
    input  logic              frame_sync,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [7:0]        leds1,
    output logic [7:0]        leds2,
    output logic [7:0]        leds3,
    output logic [7:0]        leds4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Returns {found, index} of the first requester after 'last', wrapping.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
        logic [IW:0]   res;
        logic [IW-1:0] sel;
        int            idx;
        res = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            sel = IW'(idx);
            if (r[sel]) begin
                res = {1'b1, sel};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [3:0][7:0] front_q, front_d;
    logic [3:0][7:0] back_q, back_d;

    logic [IW:0]     pick_s;
    logic            own_req_s, own_wr_s, own_commit_s;
    logic [1:0]      own_col_s;
    logic [7:0]      own_data_s;

    // Next-state logic for arbitration, buffer writes and the frame swap.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        front_d      = front_q;
        back_d       = back_q;
        pick_s       = rr_pick(req, last_q);
        own_req_s    = req[owner_q];
        own_wr_s     = wr_en[owner_q];
        own_commit_s = commit[owner_q];
        own_col_s    = wr_col[2*owner_q +: 2];
        own_data_s   = wr_data[8*owner_q +: 8];

        case (state_q)
            S_IDLE: begin
                if (pick_s[IW]) begin
                    owner_d = pick_s[IW-1:0];
                    last_d  = pick_s[IW-1:0];
                    gnt_d   = onehot(pick_s[IW-1:0]);
                    cnt_d   = '0;
                    back_d  = front_q;
                    state_d = S_GRANT;
                end else begin
                    gnt_d = '0;
                end
            end
            S_GRANT: begin
                // A write in the commit or drop cycle still lands before the decision.
                if (own_wr_s) begin
                    back_d[own_col_s] = own_data_s;
                end else begin
                    back_d = back_q;
                end
                if (own_commit_s) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (!own_req_s) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (own_wr_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (frame_sync) begin
                    front_d = back_q;
                    done_d  = onehot(owner_q);
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            front_q <= {4{RST_PAT}};
            back_q  <= {4{RST_PAT}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            front_q <= front_d;
            back_q  <= back_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign leds1 = front_q[0];
    assign leds2 = front_q[1];
    assign leds3 = front_q[2];
    assign leds4 = front_q[3];

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed scenarios followed by random traffic for led_frame_arbiter,
// checked against a transaction-level model of the arbitration rules.
module tb_led_frame_arbiter;
    localparam int         NREQ    = 2;
    localparam int         TIMEOUT = 8;
    localparam logic [7:0] RST_PAT = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, gnt, wr_en, commit, done;
    logic [3:0] wr_col;
    logic [15:0] wr_data;
    logic       frame_sync, busy;
    logic [7:0] leds1, leds2, leds3, leds4;

    int total = 0;
    int bad   = 0;

    led_frame_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .RST_PAT(RST_PAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .wr_en(wr_en),
        .wr_col(wr_col), .wr_data(wr_data), .commit(commit),
        .frame_sync(frame_sync), .done(done), .busy(busy),
        .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the buffer, whether a swap is pending, buffer contents.
    logic       m_owner;
    logic       m_last;
    int         m_idle;
    bit         m_granted, m_waiting;
    logic [7:0] m_front [4];
    logic [7:0] m_back  [4];
    logic [1:0] m_gnt, m_done;
    logic       m_busy;

    task automatic m_reset();
        m_granted = 1'b0;
        m_waiting = 1'b0;
        m_owner   = 1'b0;
        m_last    = 1'b1;
        m_idle    = 0;
        for (int i = 0; i < 4; i++) begin
            m_front[i] = RST_PAT;
            m_back[i]  = RST_PAT;
        end
        m_gnt  = 2'b00;
        m_done = 2'b00;
        m_busy = 1'b0;
    endtask

    task automatic m_step();
        m_done = 2'b00;
        if (m_waiting) begin
            if (frame_sync) begin
                for (int i = 0; i < 4; i++) m_front[i] = m_back[i];
                m_done[m_owner] = 1'b1;
                m_waiting = 1'b0;
            end
        end else if (m_granted) begin
            if (wr_en[m_owner]) m_back[wr_col[2*m_owner +: 2]] = wr_data[8*m_owner +: 8];
            if (commit[m_owner]) begin
                m_granted = 1'b0;
                m_waiting = 1'b1;
            end else if (!req[m_owner]) begin
                m_granted = 1'b0;
            end else if (wr_en[m_owner]) begin
                m_idle = 0;
            end else if (m_idle == TIMEOUT - 1) begin
                m_granted = 1'b0;
            end else begin
                m_idle++;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                logic c;
                c = 1'((int'(m_last) + k) % NREQ);
                if (!m_granted && req[c]) begin
                    m_owner   = c;
                    m_last    = c;
                    m_granted = 1'b1;
                    m_idle    = 0;
                    for (int i = 0; i < 4; i++) m_back[i] = m_front[i];
                end
            end
        end
        m_gnt  = m_granted ? (2'b01 << m_owner) : 2'b00;
        m_busy = m_granted || m_waiting;
    endtask

    function automatic logic [31:0] m_leds();
        return {m_front[0], m_front[1], m_front[2], m_front[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
        chk("model_gnt", 32'(gnt), 32'(m_gnt));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_leds", {leds1, leds2, leds3, leds4}, m_leds());
        wr_en      = 2'b00;
        commit     = 2'b00;
        frame_sync = 1'b0;
    endtask

    task automatic wr(input logic who, input logic [1:0] col, input logic [7:0] d);
        wr_en   = 2'b01 << who;
        wr_col  = {col, col};
        wr_data = {d, d};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req = 2'b00; wr_en = 2'b00; commit = 2'b00;
        wr_col = 4'h0; wr_data = 16'h0000; frame_sync = 1'b0;
        m_reset();
        #12;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_leds", {leds1, leds2, leds3, leds4}, 32'h5A5A5A5A);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: single owner fills all columns, swap on sync
        req = 2'b01;
        cyc();
        chk("t1_gnt", 32'(gnt), 32'h1);
        wr(1'b0, 2'd0, 8'h11); cyc();
        wr(1'b0, 2'd1, 8'h22); cyc();
        wr(1'b0, 2'd2, 8'h44); cyc();
        wr(1'b0, 2'd3, 8'h88); cyc();
        commit = 2'b01; cyc();
        chk("t1_wait_busy", 32'(busy), 32'h1);
        req = 2'b00;
        repeat (4) cyc();
        chk("t1_pre_sync_leds", {leds1, leds2, leds3, leds4}, 32'h5A5A5A5A);
        frame_sync = 1'b1; cyc();
        chk("t1_leds", {leds1, leds2, leds3, leds4}, 32'h11224488);
        chk("t1_done", 32'(done), 32'h1);
        cyc();
        chk("t1_done_end", 32'(done), 32'h0);

        // Scenario 2: simultaneous requests, round robin after done
        do_reset();
        req = 2'b11;
        cyc();
        chk("t2_gnt0", 32'(gnt), 32'h1);
        wr(1'b0, 2'd3, 8'h3C); cyc();
        commit = 2'b01; cyc();
        frame_sync = 1'b1; cyc();
        chk("t2_done0", 32'(done), 32'h1);
        chk("t2_leds", {leds1, leds2, leds3, leds4}, 32'h5A5A5A3C);
        cyc();
        chk("t2_gnt1", 32'(gnt), 32'h2);
        wr(1'b0, 2'd0, 8'h99); cyc();
        commit = 2'b10; cyc();
        frame_sync = 1'b1; cyc();
        chk("t2_done1", 32'(done), 32'h2);
        chk("t2_nonowner_ignored", {leds1, leds2, leds3, leds4}, 32'h5A5A5A3C);
        req = 2'b00; cyc();

        // Scenario 3: owner writes then drops request
        req = 2'b01; cyc();
        chk("t3_gnt", 32'(gnt), 32'h1);
        wr(1'b0, 2'd2, 8'hF0); cyc();
        req = 2'b00; cyc();
        chk("t3_gnt_drop", 32'(gnt), 32'h0);
        chk("t3_busy", 32'(busy), 32'h0);
        repeat (3) begin
            cyc();
            chk("t3_no_done", 32'(done), 32'h0);
        end
        chk("t3_leds", {leds1, leds2, leds3, leds4}, 32'h5A5A5A3C);

        // Scenario 4: idle owner times out, other requester follows
        req = 2'b11; cyc();
        n = 0;
        for (int i = 0; i < 20 && gnt == 2'b10; i++) begin
            n++;
            cyc();
        end
        chk("t4_timeout_cycles", 32'(n), 32'd8);
        chk("t4_no_done", 32'(done), 32'h0);
        cyc();
        chk("t4_next_gnt", 32'(gnt), 32'h1);

        // Scenario 5: sync in the commit cycle is not used
        req = 2'b01;
        wr(1'b0, 2'd1, 8'h77); cyc();
        commit = 2'b01; frame_sync = 1'b1; cyc();
        chk("t5_leds_hold", {leds1, leds2, leds3, leds4}, 32'h5A5A5A3C);
        chk("t5_busy", 32'(busy), 32'h1);
        req = 2'b00;
        cyc(); cyc();
        frame_sync = 1'b1; cyc();
        chk("t5_leds_swap", {leds1, leds2, leds3, leds4}, 32'h5A775A3C);
        chk("t5_done", 32'(done), 32'h1);
        cyc();

        // Scenario 6: reset while waiting for sync loses the swap
        req = 2'b10; cyc();
        chk("t6_gnt", 32'(gnt), 32'h2);
        wr(1'b1, 2'd0, 8'hEE); cyc();
        commit = 2'b10; cyc();
        chk("t6_wait_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_done", 32'(done), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_leds", {leds1, leds2, leds3, leds4}, 32'h5A5A5A5A);
        m_reset();
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        frame_sync = 1'b1; cyc();
        chk("t6_sync_no_effect", {leds1, leds2, leds3, leds4}, 32'h5A5A5A5A);
        chk("t6_no_done", 32'(done), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            wr_en      = 2'($urandom_range(0, 3));
            wr_col     = 4'($urandom);
            wr_data    = 16'($urandom);
            commit     = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            frame_sync = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
